// File: rtl/adder_issue_queue_pkg.sv
// Shared defaults for the adder issue queue and the stallable pipeline adder.
package adder_issue_queue_pkg;

  localparam int ADDER_WIDTH   = 32;
  localparam int ADDER_LATENCY = 4;
  localparam int AIQ_DEPTH     = 4;

  // A queue entry is {a, b, cin}.
  function automatic int fifo_data_w(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/adder_issue_queue_sync_fifo.sv
// Circular FIFO with read/write pointers and occupancy count. No bypass:
// a pushed entry appears at the head no earlier than the next cycle.
module adder_issue_queue_sync_fifo #(
  parameter int DW    = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wr_data,
  input  logic                     pop,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

  // Storage array: data only, no reset needed since count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/stallable_pipeline_adder.sv
// LATENCY-stage adder; every stage holds while stop is high.
module stallable_pipeline_adder
  import adder_issue_queue_pkg::*;
#(
  parameter int WIDTH   = ADDER_WIDTH,
  parameter int LATENCY = ADDER_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cin_a,
  input  logic [WIDTH-1:0] cin_b,
  input  logic             c_in,
  input  logic             stop,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] stage [LATENCY];

  // Add in the first stage, then carry the result down the remaining stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else if (!stop) begin
      stage[0] <= {1'b0, cin_a} + {1'b0, cin_b} + (WIDTH+1)'(c_in);
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign {c_out, sum} = stage[LATENCY-1];

endmodule

// File: rtl/adder_issue_queue.sv
// Operand issue queue feeding stallable_pipeline_adder, with a tag pipeline
// that mirrors the adder stages to flag when sum/c_out hold a real result.
module adder_issue_queue
  import adder_issue_queue_pkg::*;
#(
  parameter int WIDTH   = ADDER_WIDTH,
  parameter int DEPTH   = AIQ_DEPTH,
  parameter int LATENCY = ADDER_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic                   in_cin,
  output logic [WIDTH-1:0]       cin_a,
  output logic [WIDTH-1:0]       cin_b,
  output logic                   c_in,
  output logic                   stop,
  input  logic [WIDTH-1:0]       sum,
  input  logic                   c_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_sum,
  output logic                   res_cout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int DW = fifo_data_w(WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0]      head;
  logic [CW-1:0]      fifo_cnt;
  logic               full, empty;
  logic               push, pop, issue;
  logic [LATENCY-1:0] tag;

  // Reset forces every control output quiet, even before the reset edge
  // has cleared the registers.
  assign in_ready  = ~rst & ~full;
  assign push      = in_valid & in_ready;
  assign issue     = ~rst & ~empty;
  assign stop      = ~rst & tag[LATENCY-1] & ~res_ready;
  assign pop       = issue & ~stop;
  assign res_valid = ~rst & tag[LATENCY-1];
  assign res_sum   = sum;
  assign res_cout  = c_out;
  assign count     = rst ? '0 : fifo_cnt;

  // An empty queue issues a zero bubble rather than stalling.
  assign {cin_a, cin_b, c_in} = issue ? head : '0;

  adder_issue_queue_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({in_a, in_b, in_cin}),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_cnt),
    .full    (full),
    .empty   (empty)
  );

  // Tag pipeline advances in lockstep with the adder stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag <= '0;
    end else if (!stop) begin
      tag[0] <= issue;
      for (int i = 1; i < LATENCY; i++) tag[i] <= tag[i-1];
    end
  end

endmodule

// File: tb/tb_adder_issue_queue.sv
// Scoreboard bench: issue queue plus pipeline adder, random and directed traffic.
module tb_adder_issue_queue;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 4;

  typedef logic [127:0] v_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_cin;
  logic [WIDTH-1:0]  in_a, in_b;
  logic [WIDTH-1:0]  cin_a, cin_b, sum, res_sum;
  logic              c_in, stop, c_out, res_valid, res_ready, res_cout;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  logic [2*WIDTH:0] pend_q [$];   // operands accepted but not yet issued
  logic [WIDTH:0]   exp_q  [$];   // expected {c_out,sum} in order
  int               run_len = 0, last_run = 0;
  logic             prev_stop = 1'b0;
  logic [WIDTH:0]   prev_res = '0;

  always #5 clk = ~clk;

  adder_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .cin_a(cin_a), .cin_b(cin_b), .c_in(c_in), .stop(stop),
    .sum(sum), .c_out(c_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .count(count)
  );

  stallable_pipeline_adder #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_add (
    .clk(clk), .rst(rst), .cin_a(cin_a), .cin_b(cin_b), .c_in(c_in),
    .stop(stop), .sum(sum), .c_out(c_out)
  );

  task automatic chk(input string name, input v_t act, input v_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / reference model: sampled mid-cycle, before the coming edge.
  always @(negedge clk) begin
    logic do_push, do_pop;
    logic [2*WIDTH:0] op;
    if (rst) begin
      chk("rst_in_ready", v_t'(in_ready), 0);
      chk("rst_res_valid", v_t'(res_valid), 0);
      chk("rst_stop", v_t'(stop), 0);
      chk("rst_issue", v_t'({cin_a, cin_b, c_in}), 0);
      pend_q.delete();
      exp_q.delete();
      prev_stop = 1'b0;
      run_len = 0;
    end else begin
      chk("count", v_t'(count), v_t'(pend_q.size()));
      chk("in_ready", v_t'(in_ready), v_t'(pend_q.size() != DEPTH));
      if (pend_q.size() == 0) chk("issue_bubble", v_t'({cin_a, cin_b, c_in}), 0);
      else                    chk("issue_head", v_t'({cin_a, cin_b, c_in}), v_t'(pend_q[0]));
      chk("stop", v_t'(stop), v_t'(res_valid && !res_ready));
      if (prev_stop) begin
        chk("stall_valid", v_t'(res_valid), 1);
        chk("stall_data", v_t'({res_cout, res_sum}), v_t'(prev_res));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL result_unexpected: got %0h expected none", {res_cout, res_sum});
        end else begin
          chk("result", v_t'({res_cout, res_sum}), v_t'(exp_q.pop_front()));
        end
      end
      if (res_valid) run_len++;
      else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
      // next edge: pop if something queued and output not stalled; push if room
      do_push = in_valid && (pend_q.size() != DEPTH);
      do_pop  = (pend_q.size() != 0) && !(res_valid && !res_ready);
      op = {in_a, in_b, in_cin};
      if (do_pop) void'(pend_q.pop_front());
      if (do_push) begin
        pend_q.push_back(op);
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + (WIDTH+1)'(in_cin));
      end
      prev_stop = stop;
      prev_res  = {res_cout, res_sum};
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    int n = 0;
    bit ok = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    while (!ok && n < 50) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin step(); lat++; end
    if (!res_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin step(); n++; end
    chk("drain_empty", v_t'(exp_q.size()), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; res_ready = 1'b1;
    repeat (3) step();
    @(negedge clk); chk("rst_count", v_t'(count), 0);
    step(); rst = 1'b0;
    @(negedge clk); chk("post_rst_in_ready", v_t'(in_ready), 1);
    step();

    // 1: single op; res_valid is seen after the 4th edge following the accept
    // edge (5 edges counting the accept edge itself), for exactly one cycle
    push_op(32'd1, 32'd1, 1'b0);
    wait_valid(lat);
    chk("t1_latency", v_t'(lat), v_t'(LATENCY));
    chk("t1_sum", v_t'({res_cout, res_sum}), 33'h2);
    step();
    chk("t1_pulse", v_t'(res_valid), 0);

    // 2: carry out of the top bit
    push_op(32'hFFFF_FFFF, 32'h0, 1'b1);
    wait_valid(lat);
    chk("t2_carry", v_t'({res_cout, res_sum}), 33'h1_0000_0000);
    repeat (3) step();

    // 3: back-to-back burst, results must emerge without gaps
    for (int k = 0; k < 6; k++) push_op(32'h10 * k + 1, 32'(k), 1'b0);
    drain();
    repeat (2) step();
    chk("t3_burst_run", v_t'(last_run), 6);

    // 4: 3-cycle stall with a valid result, then fill the queue while stalled
    push_op(32'h1234, 32'h4321, 1'b1);
    wait_valid(lat);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stop", v_t'(stop), 1);
      chk("t4_hold", v_t'({res_cout, res_sum}), 33'h5556);
      step();
    end
    for (int k = 0; k < DEPTH; k++) push_op(32'hA0 + k, 32'h5 * k, k[0]);
    in_valid = 1'b1; in_a = 32'hDEAD; in_b = 32'hBEEF; in_cin = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_full_count", v_t'(count), v_t'(DEPTH));
      chk("t4_full_ready", v_t'(in_ready), 0);
      step();
    end
    res_ready = 1'b1;
    push_op(32'hDEAD, 32'hBEEF, 1'b1);
    drain();
    repeat (4) step();

    // 5: res_ready low with only bubbles at the output does not stall
    res_ready = 1'b0;
    @(negedge clk); chk("t5_no_stop", v_t'(stop), 0);
    step();
    push_op(32'h77, 32'h88, 1'b0);
    wait_valid(lat);
    chk("t5_latency", v_t'(lat), v_t'(LATENCY));
    @(negedge clk); chk("t5_stop_now", v_t'(stop), 1);
    step(); res_ready = 1'b1;
    drain();
    repeat (2) step();

    // 6: reset with 3 queued and 2 in flight discards everything
    res_ready = 1'b0;
    push_op(32'h111, 32'h222, 1'b0);
    push_op(32'h333, 32'h444, 1'b1);
    wait_valid(lat);
    for (int k = 0; k < 3; k++) push_op(32'h900 + k, 32'h1, 1'b0);
    @(negedge clk); chk("t6_queued", v_t'(count), 3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk); chk("t6_count_clr", v_t'(count), 0);
    step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); chk("t6_no_valid", v_t'(res_valid), 0);
      step();
    end
    push_op(32'hCAFE, 32'h1, 1'b1);
    wait_valid(lat);
    chk("t6_fresh", v_t'({res_cout, res_sum}), 33'hCB00);
    drain();

    // random traffic with random consumer backpressure
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
      in_b      = $urandom;
      in_cin    = $urandom_range(0, 1) == 1;
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; res_ready = 1'b1;
    drain();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
